// File: rtl/l41_decoder.sv
// l41_decoder: registered 2-to-4 one-hot decoder with enable.
// Y is the one-hot decode of A, gated by EN, and appears one clock after the
// inputs are sampled. There is no combinational path from A or EN to Y.
// OUT_ACTIVE_LOW inverts every Y bit, so the idle value becomes 4'b1111.
// There is no handshake: new A/EN values are accepted on every rising edge.
module l41_decoder #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] A,
  input  logic       EN,
  output logic [3:0] Y
);

  // Value driven on Y when no line is asserted (reset or EN low).
  localparam logic [3:0] IDLE = OUT_ACTIVE_LOW ? 4'b1111 : 4'b0000;

  logic [3:0] dec_hi;
  logic [3:0] dec_out;

  // Active-high one-hot decode, then output polarity applied.
  always_comb begin
    dec_hi = 4'b0000;
    if (EN) begin
      dec_hi = 4'b0001 << A;
    end
    dec_out = OUT_ACTIVE_LOW ? ~dec_hi : dec_hi;
  end

  // Output register; synchronous reset takes priority over EN and A.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Y <= IDLE;
    end else begin
      Y <= dec_out;
    end
  end

endmodule

// File: tb/tb_l41_decoder.sv
// tb_l41_decoder: table-driven check of l41_decoder with both output
// polarities instantiated side by side on shared inputs.
module tb_l41_decoder;

  logic       clk;
  logic       rst_n;
  logic [1:0] a;
  logic       en;
  logic [3:0] y_hi;
  logic [3:0] y_lo;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic [1:0] a;
    logic [3:0] exp_y;   // expected Y for the active-high instance
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  l41_decoder #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .A(a), .EN(en), .Y(y_hi)
  );

  l41_decoder #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .A(a), .EN(en), .Y(y_lo)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // Drive one vector at the falling edge, then sample both outputs 1 unit
  // after the next rising edge against the scoreboard entry.
  task automatic apply(input vec_t v, input int idx);
    logic [3:0] e;
    @(negedge clk);
    rst_n = v.rst_n;
    en    = v.en;
    a     = v.a;
    exp_q.push_back(v.exp_y);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("vec%0d_hi", idx), y_hi, e);
    check($sformatf("vec%0d_lo", idx), y_lo, ~e);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    a     = 2'b00;

    // Reset held two edges with EN=1, A=10, then release.
    vecs[0]  = '{1'b0, 1'b1, 2'b10, 4'b0000};
    vecs[1]  = '{1'b0, 1'b1, 2'b10, 4'b0000};
    vecs[2]  = '{1'b1, 1'b1, 2'b10, 4'b0100};
    // Enabled sweep.
    vecs[3]  = '{1'b1, 1'b1, 2'b00, 4'b0001};
    vecs[4]  = '{1'b1, 1'b1, 2'b01, 4'b0010};
    vecs[5]  = '{1'b1, 1'b1, 2'b10, 4'b0100};
    vecs[6]  = '{1'b1, 1'b1, 2'b11, 4'b1000};
    // Disabled sweep.
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 4'b0000};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 4'b0000};
    vecs[9]  = '{1'b1, 1'b0, 2'b10, 4'b0000};
    vecs[10] = '{1'b1, 1'b0, 2'b11, 4'b0000};
    // Re-enable sweep: no residual state.
    vecs[11] = '{1'b1, 1'b1, 2'b00, 4'b0001};
    vecs[12] = '{1'b1, 1'b1, 2'b01, 4'b0010};
    vecs[13] = '{1'b1, 1'b1, 2'b10, 4'b0100};
    vecs[14] = '{1'b1, 1'b1, 2'b11, 4'b1000};
    // Mid-run reset.
    vecs[15] = '{1'b0, 1'b1, 2'b11, 4'b0000};
    vecs[16] = '{1'b1, 1'b1, 2'b01, 4'b0010};
    // Back-to-back changes and EN toggling.
    vecs[17] = '{1'b1, 1'b1, 2'b11, 4'b1000};
    vecs[18] = '{1'b1, 1'b0, 2'b11, 4'b0000};
    vecs[19] = '{1'b1, 1'b1, 2'b00, 4'b0001};
    vecs[20] = '{1'b1, 1'b1, 2'b10, 4'b0100};
    vecs[21] = '{1'b1, 1'b1, 2'b01, 4'b0010};

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i], i);
    end

    // No combinational path: inputs changing after an edge leave Y alone.
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; a = 2'b10;
    @(posedge clk);
    #1;
    check("edge_decode_hi", y_hi, 4'b0100);
    a  = 2'b11;
    en = 1'b0;
    #2;
    check("no_comb_hi", y_hi, 4'b0100);
    check("no_comb_lo", y_lo, 4'b1011);

    // A reset pulse that is gone before the edge has no effect, and an
    // A glitch between edges is invisible.
    @(negedge clk);
    rst_n = 1'b0;
    a     = 2'b00;
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    a     = 2'b01;
    @(posedge clk);
    #1;
    check("rst_glitch_hi", y_hi, 4'b0010);
    check("rst_glitch_lo", y_lo, 4'b1101);

    // Reset then EN=0 at release: first edge decodes to idle.
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_again_lo", y_lo, 4'b1111);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    @(posedge clk);
    #1;
    check("release_dis_hi", y_hi, 4'b0000);
    check("release_dis_lo", y_lo, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l41_decoder.md
Name: l41_decoder

Overview:
- Registered 2-to-4 one-hot decoder with enable.
- Converts a 2-bit select A into a 4-bit one-hot output Y, gated by EN.
- Used as a small select/strobe generator, e.g. chip-select or write-enable fan-out, inside synchronous datapaths.
- All outputs are registered on one clock domain. Reset is synchronous and active-low.

Parameters:
- OUT_ACTIVE_LOW, 0, output polarity. 0: asserted line = 1, idle = 0. 1: every Y bit is inverted, so asserted line = 0 and idle = 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- A  input  2  select code; picks which Y line asserts
- EN  input  1  enable, active-high; when 0 no Y line asserts
- Y  output  4  registered one-hot decode of A; bit i corresponds to A == i

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low. The polarity and synchronicity are fixed.
- Reset: on a rising clk with rst_n = 0, Y takes the idle value.
  - Idle is 4'b0000 with OUT_ACTIVE_LOW = 0, and 4'b1111 with OUT_ACTIVE_LOW = 1.
  - Reset overrides EN and A.
  - rst_n low between edges has no effect until the next rising edge.
- Decode (OUT_ACTIVE_LOW = 0), evaluated on each rising clk with rst_n = 1:
  - EN = 1, A = 00 -> Y = 0001
  - EN = 1, A = 01 -> Y = 0010
  - EN = 1, A = 10 -> Y = 0100
  - EN = 1, A = 11 -> Y = 1000
  - EN = 0 -> Y = 0000, regardless of A
- OUT_ACTIVE_LOW = 1: Y is the bitwise inverse of the above table.
- Latency: exactly one clock. Inputs sampled at edge k appear on Y after edge k. No combinational path from A or EN to Y.
- Y is stable between edges. Input glitches between edges are invisible.
- At most one Y line is asserted in any cycle. After reset, Y is never a non-one-hot, non-idle value.
- EN deasserting: Y goes idle on the next edge. EN reasserting: Y decodes the A value present at that edge. There is no memory of the prior A.
- A changing while EN = 1: Y follows on the next edge; back-to-back changes every cycle are supported.
- Reset released (rst_n 0 -> 1): the first edge with rst_n = 1 performs a normal decode of the A and EN sampled at that edge.
- Unknown or X on A or EN while out of reset: Y is unspecified for that cycle only. The next known inputs restore a valid decode.
- No handshake and no backpressure; the block accepts new inputs every cycle.

Test Plan:
- Reset: rst_n = 0, EN = 1, A = 10 for 2 edges -> Y = 0000. Then rst_n = 1 -> after the next edge Y = 0100.
- Enabled sweep: EN = 1, A = 00, 01, 10, 11 on consecutive edges -> Y = 0001, 0010, 0100, 1000. Each value appears one edge after its A.
- Disabled sweep: EN = 0, A = 00, 01, 10, 11 -> Y = 0000 every cycle.
- Re-enable sweep: EN returns to 1, A = 00, 01, 10, 11 -> Y = 0001, 0010, 0100, 1000, identical to the first sweep with no residual state.
- Mid-run reset: EN = 1, A = 11 (Y = 1000), then rst_n = 0 for one edge -> Y = 0000. rst_n = 1 with A = 01 -> Y = 0010 on the following edge.
- Polarity: OUT_ACTIVE_LOW = 1, reset -> Y = 1111. EN = 1, A = 01 -> Y = 1101. EN = 0 -> Y = 1111.
